// File: rtl/control_enlace_rx.sv
// Receive link controller: comma-count acquisition, comma stripping, loss-of-lock.
// Optional IDLE_FILTER_EN: in lock, the idle symbol is dropped like a comma.
module control_enlace_rx #(
  parameter int         BC_LOCK   = 4,
  parameter int         ERR_LIMIT = 3,
  parameter logic [7:0] COMMA     = 8'hBC,
  parameter logic [7:0] IDLE      = 8'h7C
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [2:0] BC_contador,
  output logic [2:0] err_contador,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    BUSQUEDA     = 2'd0,
    ALINEANDO    = 2'd1,
    SINCRONIZADO = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_C = 3'(BC_LOCK);
  localparam logic [2:0] ERR_C  = 3'(ERR_LIMIT);
`ifdef IDLE_FILTER_EN
  localparam logic IDLE_EN = 1'b1;
`else
  localparam logic IDLE_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [2:0] bc_q, bc_d;
  logic [2:0] err_q, err_d;
  logic [7:0] dout_q, dout_d;
  logic       vout_q, vout_d;
  logic       act_q, act_d;

  logic is_comma, is_fill;
  logic [2:0] bc_inc, err_inc;

  assign is_comma = data_valid && (data_in == COMMA);
  assign is_fill  = is_comma ||
                    (IDLE_EN && data_valid && (data_in == IDLE));
  assign bc_inc   = bc_q + 3'd1;
  assign err_inc  = err_q + 3'd1;

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    err_d   = err_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    case (state_q)
      BUSQUEDA: begin
        bc_d  = 3'd0;
        err_d = 3'd0;
        if (is_comma) begin
          bc_d    = 3'd1;
          state_d = (LOCK_C == 3'd1) ? SINCRONIZADO : ALINEANDO;
        end
      end
      ALINEANDO: begin
        err_d = 3'd0;
        if (is_comma) begin
          bc_d = bc_inc;
          if (bc_inc == LOCK_C) state_d = SINCRONIZADO;
        end else if (data_valid) begin
          bc_d    = 3'd0;
          state_d = BUSQUEDA;
        end
      end
      SINCRONIZADO: begin
        bc_d = LOCK_C;
        if (data_valid) begin
          err_d = 3'd0;
          if (!is_fill) begin
            dout_d = data_in;
            vout_d = 1'b1;
          end
        end else if (err_inc == ERR_C) begin
          state_d = BUSQUEDA;
          bc_d    = 3'd0;
          err_d   = 3'd0;
        end else begin
          err_d = err_inc;
        end
      end
      default: begin
        state_d = BUSQUEDA;
        bc_d    = 3'd0;
        err_d   = 3'd0;
      end
    endcase
  end

  assign act_d = (state_d == SINCRONIZADO);

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= BUSQUEDA;
      bc_q    <= 3'd0;
      err_q   <= 3'd0;
      dout_q  <= 8'h00;
      vout_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      act_q   <= act_d;
    end
  end

  assign data_out     = dout_q;
  assign valid_out    = vout_q;
  assign active       = act_q;
  assign BC_contador  = bc_q;
  assign err_contador = err_q;
  assign estado       = state_q;

endmodule

// File: doc/control_enlace_rx.md
# control_enlace_rx

Receive-side link controller that sits directly after `serial_paralelo` in the `clk_4f` domain. It takes byte-aligned words, and sequences link acquisition by counting consecutive 8'hBC comma symbols. It declares the link active, strips commas from the payload stream, and drops the link back to search when valid input stops for too long. Its `active` and `BC_contador` outputs replace the per-converter status signals as the single link-state source for downstream logic.

## Interface
Parameters:
- `BC_LOCK`, 4: consecutive commas required to declare lock (legal range 1-7).
- `ERR_LIMIT`, 3: consecutive invalid cycles in SINCRONIZADO that cause loss of lock (legal range 1-7).
- `COMMA`, 8'hBC: alignment symbol.
- `IDLE`, 8'h7C: idle symbol. Only used when `IDLE_FILTER_EN` is defined.

Ports:
- `clk_4f`  input  1: byte clock, the only clock. All logic is on its rising edge.
- `reset`  input  1: synchronous reset, active-high.
- `data_in`  input  8: parallel byte from the serial-to-parallel converter.
- `data_valid`  input  1: `data_in` holds an aligned byte this cycle.
- `data_out`  output  8: payload byte, registered.
- `valid_out`  output  1: `data_out` is a payload byte this cycle.
- `active`  output  1: link locked (state SINCRONIZADO).
- `BC_contador`  output  3: consecutive-comma count.
- `err_contador`  output  3: consecutive invalid-cycle count in SINCRONIZADO.
- `estado`  output  2: FSM state. 0 = BUSQUEDA, 1 = ALINEANDO, 2 = SINCRONIZADO. 3 is unused and must never be reached.

## Operation
- Reset: the edge with `reset`=1 forces estado=BUSQUEDA and sets all outputs to zero (data_out=8'h00, valid_out=0, active=0, BC_contador=0, err_contador=0). Reset wins over every other condition, in every state.
- BUSQUEDA:
  - `data_valid` & `data_in`==COMMA: BC_contador=1. Go to ALINEANDO, or directly to SINCRONIZADO with active=1 if BC_LOCK==1.
  - Otherwise: stay, with counters held at 0.
- ALINEANDO:
  - `data_valid` & COMMA: BC_contador+1. When the new value equals BC_LOCK, go to SINCRONIZADO with active=1 on the same edge.
  - `data_valid` & non-comma: BC_contador=0, go to BUSQUEDA.
  - `!data_valid`: hold state and count.
- SINCRONIZADO:
  - BC_contador holds BC_LOCK and active stays 1.
  - `data_valid` & COMMA: no payload (valid_out=0), err_contador=0.
  - `data_valid` & other byte: data_out=data_in, valid_out=1, err_contador=0.
  - `!data_valid`: valid_out=0 and err_contador+1. When the new value equals ERR_LIMIT, go to BUSQUEDA on the same edge with active=0, BC_contador=0, err_contador=0.
- `data_out` holds its last payload value whenever valid_out=0. It is cleared only by reset.
- Counters never wrap:
  - BC_contador never exceeds BC_LOCK.
  - err_contador never exceeds ERR_LIMIT-1 while in SINCRONIZADO.

## Timing
- All outputs are registered. Latency from sampled input to `data_out`/`valid_out` is 1 `clk_4f` cycle.
- `active` rises on the edge that samples the BC_LOCK-th consecutive valid comma.
- The first payload byte can appear on the cycle after the first valid non-comma sample taken in SINCRONIZADO.
- Commas arriving in ALINEANDO with `data_valid` gaps between them still count as consecutive. Gaps do not break alignment.
- When a non-comma arrives in ALINEANDO exactly as BC_contador==BC_LOCK-1, the non-comma wins: the controller returns to BUSQUEDA.
- `active` falls on the edge that samples the ERR_LIMIT-th consecutive invalid cycle. valid_out is 0 on that edge.
- Reset asserted mid-stream: outputs are zero on the next edge. Reacquisition requires BC_LOCK fresh commas.

## Configuration
- `IDLE_FILTER_EN` defined:
  - In SINCRONIZADO, `data_valid` & `data_in`==IDLE is handled like a comma: no payload, err_contador=0.
  - In BUSQUEDA/ALINEANDO, IDLE is treated as a non-comma.
- `IDLE_FILTER_EN` undefined: IDLE is ordinary payload and is forwarded with valid_out=1.

## Test plan
- Reset held 2 cycles with data_valid=1 and data_in=8'hBC → all outputs 0 and estado=0 throughout.
- Four consecutive valid 8'hBC, then 8'h5A and 8'hA5 → BC_contador steps 1,2,3,4. active=1 on the 4th-comma edge. data_out=8'h5A then 8'hA5, each with valid_out=1 one cycle after its sample.
- Commas interrupted: 8'hBC, 8'hBC, 8'h11, then 4× 8'hBC → BC_contador goes 1,2,0, then 1..4. Lock occurs only after the final 4.
- Locked link, data_valid=0 for 3 cycles → err_contador 1,2, then active=0, estado=0, all counters 0. With only 2 invalid cycles followed by a valid byte, err_contador returns to 0 and lock is kept.
- Locked, stream 8'h7C, 8'h33 → with `IDLE_FILTER_EN`: only 8'h33 is output. Without it: 8'h7C then 8'h33, both with valid_out=1.
- Reset pulsed one cycle while locked and streaming → active=0 next edge and no valid_out until 4 new commas are received.
